mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 32, width of the stall-cycle counter.
REQ-002 SHALL have clock port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have reset port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: valid_in  in  1  EX/MEM slot holds a valid instruction.
REQ-005 SHALL have ports: is_load  in  1; is_store  in  1  (memory opcode flags from the control word).
REQ-006 SHALL have port: funct3  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 SHALL have ports: addr  in  32  effective address (ALU result); store_data  in  32  rs2 value.
REQ-008 SHALL have ports: data_read  out  1; data_write  out  1  (data-cache request strobes).
REQ-009 SHALL have ports: data_addr  out  32; data_mbe  out  4; data_wdata  out  32.
REQ-010 SHALL have ports: data_rdata  in  32; data_resp  in  1  (cache response, 1-cycle pulse).
REQ-011 SHALL have ports: rdata_o  out  32; resp_o  out  1  (feed MEM/WB data_rdata_in/data_resp).
REQ-012 SHALL have port: mem_byte_en_o  out  4  lane mask for WB load extraction.
REQ-013 SHALL have ports: stall_o  out  1  freeze upstream stages; misalign_o  out  1  misaligned-access flag.
REQ-014 SHALL have port: stall_cycles_o  out  STALL_CNT_W  count of cycles with stall_o high.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS.
REQ-016 Request = valid_in & (is_load | is_store) & ~misaligned; misaligned = (h/hu with addr[0]) or (w with addr[1:0] != 0).
REQ-017 IDLE with request: stall_o=1 combinationally; next state ACCESS; data_* outputs registered from current inputs.
REQ-018 ACCESS: data_read=is_load-latched, data_write=is_store-latched, held stable every cycle until data_resp sampled high.
REQ-019 data_addr SHALL be {addr[31:2],2'b00}.
REQ-020 Lane mask: b/bu 4'b0001<<addr[1:0]; h/hu 4'b0011<<{addr[1],1'b0}; w 4'b1111; data_mbe = mask for stores, 4'b1111 for loads.
REQ-021 data_wdata: sb store_data<<(8*addr[1:0]); sh store_data<<(16*addr[1]); sw store_data unshifted.
REQ-022 ACCESS with data_resp=0: stall_o=1; with data_resp=1: stall_o=0, resp_o=1, rdata_o=data_rdata, next state IDLE, strobes low next cycle.
REQ-023 mem_byte_en_o SHALL present the latched lane mask throughout ACCESS, 0 in IDLE.
REQ-024 rdata_o SHALL pass data_rdata combinationally; resp_o SHALL be 0 outside ACCESS.
REQ-025 data_resp in IDLE SHALL be ignored (no resp_o, no state change).
REQ-026 Misaligned valid memory op in IDLE: misalign_o=1 that cycle, no strobes, stall_o=0, state stays IDLE.
REQ-027 Non-memory or invalid slot: stall_o=0, no strobes, instruction passes in one cycle.
REQ-028 Back-to-back accesses: second request accepted in the IDLE cycle following the response; minimum 2 cycles per access.
REQ-029 Inputs changing during ACCESS SHALL not affect the outstanding access.

Reset
REQ-030 rst SHALL force IDLE; data_read, data_write, data_mbe, data_addr, data_wdata, mem_byte_en_o, stall_cycles_o all 0.
REQ-031 rst during ACCESS SHALL abandon the access: strobes 0 next cycle, a coincident data_resp yields resp_o=0.
REQ-032 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 Macro MEM_STALL_CNT_EN defined: stall_cycles_o increments each non-reset cycle with stall_o=1, saturating at all-ones.
REQ-034 Macro MEM_STALL_CNT_EN undefined: no counter logic; stall_cycles_o tied to 0.

Verification
REQ-035 lw addr 0x100, resp after 3 ACCESS cycles, data_rdata 0xDEADBEEF -> stall_o high 4 cycles, resp_o 1 cycle, rdata_o 0xDEADBEEF, mbe 4'b1111.
REQ-036 sb addr 0x203, store_data 0x000000AB -> data_addr 0x200, data_mbe 4'b1000, data_wdata 0xAB000000, data_write until resp.
REQ-037 lh addr 0x101 -> misalign_o=1 one cycle, data_read never asserted, stall_o=0.
REQ-038 rst asserted in 2nd ACCESS cycle with data_resp=1 -> resp_o=0, strobes 0 next cycle, state IDLE.
REQ-039 Two back-to-back sw, resp after 1 cycle each -> four cycles total, stall_cycles_o=2 with MEM_STALL_CNT_EN, 0 without.
REQ-040 data_resp pulse while IDLE with add in slot -> resp_o=0, stall_o=0, no strobes.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage front-end for a single-port data cache.
//
// A valid, aligned load/store in the EX/MEM slot is accepted in IDLE. The
// request (address, byte mask, lane-shifted write data, strobes) is registered
// toward the cache and held unchanged in ACCESS until the cache answers with a
// one-cycle data_resp pulse. Upstream stages are frozen via stall_o while the
// access is pending. Misaligned accesses are flagged and never issued.
//
// Build option: define MEM_STALL_CNT_EN to include a saturating counter of
// stalled cycles on stall_cycles_o; without it the output is tied to zero.

module mem_stage #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [31:0]            store_data,
  output logic                   data_read,
  output logic                   data_write,
  output logic [31:0]            data_addr,
  output logic [3:0]             data_mbe,
  output logic [31:0]            data_wdata,
  input  logic [31:0]            data_rdata,
  input  logic                   data_resp,
  output logic [31:0]            rdata_o,
  output logic                   resp_o,
  output logic [3:0]             mem_byte_en_o,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Halfword needs bit 0 clear, word needs both low bits clear.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3)
      3'b001, 3'b101: mis = a[0];
      3'b010:         mis = (a != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte lanes touched by the access within the 32-bit word.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3)
      3'b000, 3'b100: m = 4'b0001 << a;
      3'b001, 3'b101: m = 4'b0011 << {a[1], 1'b0};
      default:        m = 4'b1111;
    endcase
    return m;
  endfunction

  // Move store data onto the lanes selected by the low address bits.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000, 3'b100: w = d << {a, 3'b000};
      3'b001, 3'b101: w = d << {a[1], 4'b0000};
      default:        w = d;
    endcase
    return w;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic        mem_op_s;
  logic        misaligned_s;
  logic        req_s;
  logic [3:0]  mask_s;
  logic        data_read_r;
  logic        data_write_r;
  logic [31:0] data_addr_r;
  logic [3:0]  data_mbe_r;
  logic [31:0] data_wdata_r;
  logic [3:0]  lane_r;

  assign mem_op_s     = valid_in & (is_load | is_store);
  assign misaligned_s = mem_op_s & is_misaligned(funct3, addr[1:0]);
  assign req_s        = (state_r == IDLE) & mem_op_s & ~misaligned_s;
  assign mask_s       = lane_mask(funct3, addr[1:0]);

  // Next-state: accept in IDLE, leave ACCESS on the cache response.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (data_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Combinational handshake outputs; reset masks them in its own cycle.
  always_comb begin
    stall_o    = 1'b0;
    resp_o     = 1'b0;
    misalign_o = 1'b0;
    rdata_o    = data_rdata;
    if (rst) begin
      stall_o    = 1'b0;
      resp_o     = 1'b0;
      misalign_o = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stall_o    = req_s;
          misalign_o = misaligned_s;
        end
        ACCESS: begin
          stall_o = ~data_resp;
          resp_o  = data_resp;
        end
        default: begin
          stall_o = 1'b0;
          resp_o  = 1'b0;
        end
      endcase
    end
  end

  // Cache request registers: captured on accept, frozen during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_read_r  <= 1'b0;
      data_write_r <= 1'b0;
      data_addr_r  <= 32'h0000_0000;
      data_mbe_r   <= 4'b0000;
      data_wdata_r <= 32'h0000_0000;
      lane_r       <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            data_read_r  <= is_load;
            data_write_r <= is_store;
            data_addr_r  <= {addr[31:2], 2'b00};
            data_mbe_r   <= is_store ? mask_s : 4'b1111;
            data_wdata_r <= lane_wdata(funct3, addr[1:0], store_data);
            lane_r       <= mask_s;
          end
        end
        ACCESS: begin
          if (data_resp) begin
            data_read_r  <= 1'b0;
            data_write_r <= 1'b0;
            lane_r       <= 4'b0000;
          end
        end
        default: begin
          data_read_r  <= 1'b0;
          data_write_r <= 1'b0;
          lane_r       <= 4'b0000;
        end
      endcase
    end
  end

  assign data_read     = data_read_r;
  assign data_write    = data_write_r;
  assign data_addr     = data_addr_r;
  assign data_mbe      = data_mbe_r;
  assign data_wdata    = data_wdata_r;
  assign mem_byte_en_o = lane_r;

`ifdef MEM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles in which upstream was frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (stall_o && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles_o = stall_cnt_r;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single accesses plus
// hand-written multi-cycle sequences (long load, reset mid-access,
// back-to-back stores, stray response in IDLE).

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        data_read, data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_resp;
  logic [31:0] rdata_o;
  logic        resp_o;
  logic [3:0]  mem_byte_en_o;
  logic        stall_o, misalign_o;
  logic [31:0] stall_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_seen;

  always #5 clk = ~clk;

  mem_stage #(.STALL_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_mbe(data_mbe), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_resp(data_resp), .rdata_o(rdata_o), .resp_o(resp_o),
    .mem_byte_en_o(mem_byte_en_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .stall_cycles_o(stall_cycles_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    valid_in   = v;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  typedef struct {
    logic        valid;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        e_stall;
    logic        e_mis;
    logic [31:0] e_addr;
    logic [3:0]  e_mbe;
    logic [31:0] e_wdata;
    logic [3:0]  e_lane;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // valid ld st f3 addr sd | stall mis data_addr mbe wdata lane
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 1'b1, 1'b0, 32'h0000_0200, 4'b1000, 32'hAB00_0000, 4'b1000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0100, 4'b1100, 32'h1234_0000, 4'b1100};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0104, 4'b1111, 32'hCAFE_F00D, 4'b1111};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_0055, 1'b1, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_5500, 4'b0010};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 4'b1111};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 4'b0100};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0106, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0104, 4'b1111, 32'h0000_0000, 4'b1100};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 1'b0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h0000_0101, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0103, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000};

    // ---------------- reset state ----------------
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    data_rdata = 32'h0;
    data_resp  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_read", data_read, 1'b0);
    check("rst_data_write", data_write, 1'b0);
    check("rst_data_addr", data_addr, 32'h0);
    check("rst_data_mbe", data_mbe, 4'b0000);
    check("rst_data_wdata", data_wdata, 32'h0);
    check("rst_lane", mem_byte_en_o, 4'b0000);
    check("rst_stall_cycles", stall_cycles_o, 32'h0);
    check("rst_stall", stall_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sd);
      data_resp = 1'b0;
      #1;
      check($sformatf("v%0d_stall", i), stall_o, vecs[i].e_stall);
      check($sformatf("v%0d_misalign", i), misalign_o, vecs[i].e_mis);
      check($sformatf("v%0d_resp_idle", i), resp_o, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_read", i), data_read, vecs[i].ld & vecs[i].e_stall);
      check($sformatf("v%0d_write", i), data_write, vecs[i].st & vecs[i].e_stall);
      check($sformatf("v%0d_lane", i), mem_byte_en_o, vecs[i].e_lane);
      if (vecs[i].e_stall) begin
        check($sformatf("v%0d_addr", i), data_addr, vecs[i].e_addr);
        check($sformatf("v%0d_mbe", i), data_mbe, vecs[i].e_mbe);
        check($sformatf("v%0d_wdata", i), data_wdata, vecs[i].e_wdata);
        @(negedge clk);
        valid_in   = 1'b0;
        data_resp  = 1'b1;
        data_rdata = 32'h0000_1000 + 32'(i);
        #1;
        check($sformatf("v%0d_resp", i), resp_o, 1'b1);
        check($sformatf("v%0d_rdata", i), rdata_o, 32'h0000_1000 + 32'(i));
        check($sformatf("v%0d_stall_resp", i), stall_o, 1'b0);
        @(posedge clk);
        #1;
        data_resp = 1'b0;
        check($sformatf("v%0d_read_after", i), data_read, 1'b0);
        check($sformatf("v%0d_write_after", i), data_write, 1'b0);
        check($sformatf("v%0d_lane_after", i), mem_byte_en_o, 4'b0000);
      end
    end

    // ---------------- lw 0x100, response on 4th ACCESS cycle ----------------
    stall_seen = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    #1;
    if (stall_o) stall_seen++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_FFF3, 32'h5A5A_5A5A);
      #1;
      if (stall_o) stall_seen++;
      check($sformatf("lw_wait%0d_read", c), data_read, 1'b1);
      check($sformatf("lw_wait%0d_write", c), data_write, 1'b0);
      check($sformatf("lw_wait%0d_addr", c), data_addr, 32'h0000_0100);
      check($sformatf("lw_wait%0d_resp", c), resp_o, 1'b0);
    end
    @(negedge clk);
    valid_in   = 1'b0;
    data_resp  = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall_o) stall_seen++;
    check("lw_resp", resp_o, 1'b1);
    check("lw_rdata", rdata_o, 32'hDEAD_BEEF);
    check("lw_mbe", data_mbe, 4'b1111);
    check("lw_lane", mem_byte_en_o, 4'b1111);
    check("lw_stall_cycles_seen", stall_seen, 4);
    @(posedge clk);
    #1;
    data_resp = 1'b0;
    check("lw_read_after", data_read, 1'b0);

    // ---------------- reset in 2nd ACCESS cycle with coincident resp ----------------
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("rstacc_read_c1", data_read, 1'b1);
    @(negedge clk);
    rst        = 1'b1;
    data_resp  = 1'b1;
    data_rdata = 32'h1234_5678;
    #1;
    check("rstacc_resp", resp_o, 1'b0);
    @(posedge clk);
    #1;
    check("rstacc_read_after", data_read, 1'b0);
    check("rstacc_lane_after", mem_byte_en_o, 4'b0000);
    check("rstacc_addr_after", data_addr, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    data_resp = 1'b1;
    #1;
    check("rstacc_idle_resp", resp_o, 1'b0);
    check("rstacc_idle_stall", stall_o, 1'b0);
    @(negedge clk);
    data_resp = 1'b0;

    // ---------------- two back-to-back sw ----------------
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0001);
    #1;
    check("b2b_stall0", stall_o, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    data_resp = 1'b1;
    #1;
    check("b2b_write0", data_write, 1'b1);
    check("b2b_resp0", resp_o, 1'b1);
    @(negedge clk);
    data_resp = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h0000_0002);
    #1;
    check("b2b_stall1", stall_o, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    data_resp = 1'b1;
    #1;
    check("b2b_addr1", data_addr, 32'h0000_0014);
    check("b2b_wdata1", data_wdata, 32'h0000_0002);
    check("b2b_resp1", resp_o, 1'b1);
    @(negedge clk);
    data_resp = 1'b0;
    #1;
    check("b2b_write_after", data_write, 1'b0);
`ifdef MEM_STALL_CNT_EN
    check("b2b_stall_cycles", stall_cycles_o, 32'd2);
`else
    check("b2b_stall_cycles", stall_cycles_o, 32'd0);
`endif

    // ---------------- stray response in IDLE with add in slot ----------------
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0040, 32'h0);
    data_resp = 1'b1;
    #1;
    check("idle_resp_resp", resp_o, 1'b0);
    check("idle_resp_stall", stall_o, 1'b0);
    @(posedge clk);
    #1;
    check("idle_resp_read", data_read, 1'b0);
    check("idle_resp_write", data_write, 1'b0);
    @(negedge clk);
    data_resp = 1'b0;
    valid_in  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
